// File: rtl/rv32i_pkg.sv
// Shared rv32i types for the multicycle control path: states, ALU ops,
// opcodes and datapath select encodings.
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} ctrl_state_t;

  typedef enum logic [3:0] {
    ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
    XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR  = 4'd8, AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {PC_PLUS4, PC_IMM, PC_ALU} pc_sel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
  typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_t;

  // Branch funct3 010/011 are unallocated and trap like an unknown opcode.
  function automatic logic legal_instr(logic [6:0] opc, logic [2:0] f3);
    case (opc)
      OP, OP_IMM, LOAD, STORE, JAL, JALR, LUI, AUIPC: legal_instr = 1'b1;
      BRANCH:  legal_instr = (f3[2:1] != 2'b01);
      default: legal_instr = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// Maps opcode/funct3/funct7[5] to the ALU operation used in EXECUTE.
module alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_op
);
  always_comb begin
    alu_op = ADD;
    if (opcode == OP || opcode == OP_IMM) begin
      case (funct3)
        3'b000:  alu_op = (opcode == OP && funct7_5) ? SUB : ADD;
        3'b001:  alu_op = SLL;
        3'b010:  alu_op = SLT;
        3'b011:  alu_op = SLTU;
        3'b100:  alu_op = XOR;
        3'b101:  alu_op = funct7_5 ? SRA : SRL;
        3'b110:  alu_op = OR;
        default: alu_op = AND;
      endcase
    end else if (opcode == BRANCH) begin
      case (funct3)
        3'b000, 3'b001: alu_op = SUB;
        3'b100, 3'b101: alu_op = SLT;
        3'b110, 3'b111: alu_op = SLTU;
        default:        alu_op = ADD;
      endcase
    end
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle rv32i control FSM: sequences fetch/decode/execute/mem/writeback
// over one shared memory port and drives every datapath select and strobe.
module multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [ILEN-1:0]      instr,
  input  logic                 alu_zero,
  input  logic                 alu_lsb,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 reg_we,
  output logic [1:0]           wb_sel,
  output logic [1:0]           alu_src_a,
  output logic                 alu_src_b,
  output logic [3:0]           alu_op,
  output logic                 halt,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [2:0]           state_o
);
  ctrl_state_t state, nxt;
  alu_op_t     dec_op;
  logic        retire, taken;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign state_o      = state;

  alu_decoder u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .alu_op   (dec_op)
  );

  always_comb begin
    case (funct3)
      3'b000:         taken = alu_zero;
      3'b001:         taken = !alu_zero;
      3'b100, 3'b110: taken = alu_lsb;
      3'b101, 3'b111: taken = !alu_lsb;
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Outputs are gated by areset so strobes drop the instant reset asserts.
  always_comb begin
    nxt          = state;
    retire       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = 1'b0;
    alu_op       = ADD;
    halt         = 1'b0;
    if (!areset) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            nxt   = DECODE;
          end
        end
        DECODE: nxt = legal_instr(opcode, funct3) ? EXECUTE : TRAP;
        EXECUTE: begin
          alu_op = dec_op;
          nxt    = (opcode == LOAD || opcode == STORE) ? MEM : WRITEBACK;
          case (opcode)
            OP_IMM, LOAD, STORE, JALR: alu_src_b = 1'b1;
            LUI: begin
              alu_src_a = SRC_A_ZERO;
              alu_src_b = 1'b1;
            end
            AUIPC: begin
              alu_src_a = SRC_A_PC;
              alu_src_b = 1'b1;
            end
            BRANCH: begin
              pc_we  = 1'b1;
              pc_sel = taken ? PC_IMM : PC_PLUS4;
              retire = 1'b1;
              nxt    = FETCH;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == STORE);
          if (mem_ready) begin
            if (opcode == STORE) begin
              pc_we  = 1'b1;
              retire = 1'b1;
              nxt    = FETCH;
            end else begin
              nxt = WRITEBACK;
            end
          end
        end
        WRITEBACK: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
          nxt    = FETCH;
          if (opcode == LOAD)                       wb_sel = WB_MEM;
          else if (opcode == JAL || opcode == JALR) wb_sel = WB_PC4;
          if (opcode == JAL)       pc_sel = PC_IMM;
          else if (opcode == JALR) pc_sel = PC_ALU;
        end
        default: halt = 1'b1;
      endcase
    end
  end
endmodule
